periph_bus_master: RTL and testbench
====================================

Name: periph_bus_master

Overview:
- Bus initiator for the peripheral slave register interface: the end that drives write/read enables, addresses and data into a peripheral such as the UART, and collects read data and error status.
- Sits between a CPU/load-store or debug command source and one peripheral slave port.
- Buffers commands in a small FIFO, issues one single-cycle bus transaction at a time, and returns one response per command over a valid/ready handshake.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- RD_LATENCY, 1, cycles from the enable pulse cycle to the cycle whose closing edge samples i_RData/i_Err; ≥1, applies to reads and writes.

Ports:
- i_Clk  input  1  clock, rising edge.
- i_Rst  input  1  asynchronous, active-low reset.
- i_CmdValid  input  1  command valid.
- o_CmdReady  output  1  command accepted when high with i_CmdValid; equals !full.
- i_CmdWrite  input  1  1 = write, 0 = read.
- i_CmdAddr  input  32  register address.
- i_CmdData  input  32  write data; ignored for reads.
- o_RspValid  output  1  response valid.
- i_RspReady  input  1  response consumed when high with o_RspValid.
- o_RspWrite  output  1  response belongs to a write.
- o_RspData  output  32  read data; 0 for writes.
- o_RspErr  output  1  peripheral flagged an error.
- o_WEnable  output  1  write strobe to the slave.
- o_WAddr  output  32  write address.
- o_WData  output  32  write data.
- o_REnable  output  1  read strobe to the slave.
- o_RAddr  output  32  read address.
- i_RData  input  32  slave read data.
- i_Err  input  1  slave error flag.

Behaviour:
- Reset (i_Rst=0, asynchronous):
  - FIFO empty; FSM returns to IDLE.
  - All outputs 0, except o_CmdReady=1 once reset releases.
  - An in-flight transaction is abandoned and produces no response.
- FIFO: push on i_CmdValid&&o_CmdReady. Pop happens only in IDLE when not empty. A push and a pop in the same cycle keep the count unchanged. When the FIFO is full, o_CmdReady=0 and pushes are blocked even if a pop occurs that cycle.
- IDLE:
  - If the FIFO is not empty, pop the head, load the address/data registers and go to ISSUE.
  - A command pushed into an empty FIFO at edge k reaches ISSUE at edge k+1.
- ISSUE (exactly 1 cycle, "pulse cycle P"):
  - Write: o_WEnable=1, o_WAddr/o_WData driven.
  - Read: o_REnable=1, o_RAddr driven.
  - Next state is WAIT. The err accumulator is cleared on entry and ORs i_Err every cycle of ISSUE and WAIT.
- WAIT: counter runs from RD_LATENCY down to 1.
  - At the closing edge of cycle P+RD_LATENCY: capture i_RData (reads) or 0 (writes), OR in i_Err, go to RESP.
- RESP:
  - o_RspValid=1; o_RspData, o_RspErr and o_RspWrite are held stable until i_RspReady.
  - On the handshake edge go to IDLE; o_RspValid drops the next cycle.
- Enables are 1-cycle pulses only.
  - Address/data outputs hold their last values after the pulse; they do not return to 0.
  - o_WEnable and o_REnable are never high together.
- Throughput: one transaction per RD_LATENCY+3 cycles with i_RspReady tied high.
- Commands are executed and answered strictly in FIFO order. The FIFO keeps accepting commands while a transaction is outstanding.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1 so full and empty are distinguishable.

Test Plan:
- Reset, then push writes (addr 1, 13021), (addr 2, 0x55), (addr 0, 0x05) back-to-back with i_RspReady=1 -> three single-cycle o_WEnable pulses in that order with matching o_WAddr/o_WData, spaced RD_LATENCY+3 cycles apart; three responses with o_RspWrite=1, o_RspData=0, o_RspErr=0.
- Read addr 1 with the slave returning 13021 at P+RD_LATENCY -> single o_REnable pulse, o_RAddr=1; response o_RspData=13021, o_RspWrite=0.
- Write addr 7 with the slave asserting i_Err for one cycle in WAIT -> o_RspErr=1; the next command's response has o_RspErr=0.
- Hold i_RspReady=0, push DEPTH+2 commands -> o_CmdReady drops after the FIFO fills (the first command has already been popped); no further bus pulses; responses stay stable. Release i_RspReady -> all commands complete in order, none lost or duplicated.
- Assert i_Rst low during WAIT of a read -> all outputs 0 immediately and FIFO empty; no response ever appears for that read; a new command after release completes normally.
- RD_LATENCY=3 build: read addr 2 -> i_RData sampled exactly 3 cycles after the pulse cycle; a value changed one cycle earlier or later is not captured.

Source files
------------

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator: buffers read/write commands in a FIFO, issues one
// single-cycle enable pulse per command and returns one response per command.
package periph_bus_master_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;
endpackage

module periph_bus_master
  import periph_bus_master_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_CmdValid,
  output logic              o_CmdReady,
  input  logic              i_CmdWrite,
  input  logic [ADDR_W-1:0] i_CmdAddr,
  input  logic [DATA_W-1:0] i_CmdData,
  output logic              o_RspValid,
  input  logic              i_RspReady,
  output logic              o_RspWrite,
  output logic [DATA_W-1:0] o_RspData,
  output logic              o_RspErr,
  output logic              o_WEnable,
  output logic [ADDR_W-1:0] o_WAddr,
  output logic [DATA_W-1:0] o_WData,
  output logic              o_REnable,
  output logic [ADDR_W-1:0] o_RAddr,
  input  logic [DATA_W-1:0] i_RData,
  input  logic              i_Err
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  cmd_t              mem_q [DEPTH];
  cmd_t              mem_d [DEPTH];
  cmd_t              head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              push, pop;
  logic              cur_write_q, cur_write_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              err_acc_q, err_acc_d;
  logic              wen_q, wen_d, ren_q, ren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  // Command FIFO; ready is registered from the next-cycle fill level.
  always_comb begin
    push = i_CmdValid && cmd_ready_q;
    pop  = (state_q == S_IDLE) && (count_q != '0);
    head = mem_q[rd_ptr_q];
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{write: i_CmdWrite, addr: i_CmdAddr, data: i_CmdData};
    end
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    cmd_ready_d = (count_d != CNT_W'(DEPTH));
  end

  // Transaction FSM: pulse, wait out the slave latency, hold the response.
  always_comb begin
    state_d     = state_q;
    cur_write_d = cur_write_q;
    lat_cnt_d   = lat_cnt_q;
    err_acc_d   = err_acc_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    raddr_d     = raddr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d     = S_ISSUE;
          cur_write_d = head.write;
          err_acc_d   = 1'b0;
          if (head.write) begin
            wen_d   = 1'b1;
            waddr_d = head.addr;
            wdata_d = head.data;
          end else begin
            ren_d   = 1'b1;
            raddr_d = head.addr;
          end
        end
      end
      S_ISSUE: begin
        err_acc_d = err_acc_q | i_Err;
        lat_cnt_d = LAT_W'(RD_LATENCY);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        err_acc_d = err_acc_q | i_Err;
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = cur_write_q;
          rsp_data_d  = cur_write_q ? '0 : i_RData;
          rsp_err_d   = err_acc_q | i_Err;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        if (i_RspReady) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q     <= S_IDLE;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      cur_write_q <= 1'b0;
      lat_cnt_q   <= '0;
      err_acc_q   <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      cur_write_q <= cur_write_d;
      lat_cnt_q   <= lat_cnt_d;
      err_acc_q   <= err_acc_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_CmdReady = cmd_ready_q;
  assign o_RspValid = rsp_valid_q;
  assign o_RspWrite = rsp_write_q;
  assign o_RspData  = rsp_data_q;
  assign o_RspErr   = rsp_err_q;
  assign o_WEnable  = wen_q;
  assign o_WAddr    = waddr_q;
  assign o_WData    = wdata_q;
  assign o_REnable  = ren_q;
  assign o_RAddr    = raddr_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Scoreboard bench for periph_bus_master: a latency-1 instance for the main
// traffic and a latency-3 instance for exact sampling-cycle checks.
module tb_periph_bus_master;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 1;
  localparam int unsigned LAT3  = 3;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic        cmd_ready, rsp_valid, rsp_write, rsp_err, wen, ren;
  logic [31:0] rsp_data, waddr, wdata, raddr;
  logic [31:0] rdata = JUNK;
  logic        err = 1'b0;

  logic        cmd_valid3 = 1'b0;
  logic [31:0] cmd_addr3 = '0;
  logic [31:0] rdata3 = JUNK;
  logic        cmd_ready3, rsp_valid3, rsp_write3, rsp_err3, wen3, ren3;
  logic [31:0] rsp_data3, waddr3, wdata3, raddr3;

  periph_bus_master #(.DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .i_Clk(clk), .i_Rst(rst_n),
    .i_CmdValid(cmd_valid), .o_CmdReady(cmd_ready), .i_CmdWrite(cmd_write),
    .i_CmdAddr(cmd_addr), .i_CmdData(cmd_data),
    .o_RspValid(rsp_valid), .i_RspReady(rsp_ready), .o_RspWrite(rsp_write),
    .o_RspData(rsp_data), .o_RspErr(rsp_err),
    .o_WEnable(wen), .o_WAddr(waddr), .o_WData(wdata),
    .o_REnable(ren), .o_RAddr(raddr), .i_RData(rdata), .i_Err(err)
  );

  periph_bus_master #(.DEPTH(DEPTH), .RD_LATENCY(LAT3)) dut3 (
    .i_Clk(clk), .i_Rst(rst_n),
    .i_CmdValid(cmd_valid3), .o_CmdReady(cmd_ready3), .i_CmdWrite(1'b0),
    .i_CmdAddr(cmd_addr3), .i_CmdData(32'h0),
    .o_RspValid(rsp_valid3), .i_RspReady(1'b1), .o_RspWrite(rsp_write3),
    .o_RspData(rsp_data3), .o_RspErr(rsp_err3),
    .o_WEnable(wen3), .o_WAddr(waddr3), .o_WData(wdata3),
    .o_REnable(ren3), .o_RAddr(raddr3), .i_RData(rdata3), .i_Err(1'b0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic write; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct packed { logic write; logic [31:0] data; logic err; } rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   pulse_cyc[$];
  int   n_rsp = 0;
  int   n_acc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave model: register file, data/err presented only in cycle P+LAT.
  logic [31:0] smem [16];
  int          cd = 0;
  logic [31:0] pend = '0;
  logic        pend_err = 1'b0;
  always @(negedge clk) begin
    if (wen) smem[waddr[3:0]] = wdata;
    if (wen || ren) begin
      cd       = int'(LAT);
      pend     = ren ? smem[raddr[3:0]] : 32'h0;
      pend_err = ((wen ? waddr : raddr) == 32'd7);
      rdata    = JUNK;
      err      = 1'b0;
    end else if (cd > 0) begin
      cd--;
      rdata = (cd == 0) ? pend : JUNK;
      err   = (cd == 0) && pend_err;
    end else begin
      rdata = JUNK;
      err   = 1'b0;
    end
  end

  // Latency-3 slave: correct data only in cycle P+3, changing junk otherwise.
  int cd3 = 0;
  always @(negedge clk) begin
    if (ren3) begin
      cd3    = int'(LAT3);
      rdata3 = JUNK;
    end else if (cd3 > 0) begin
      cd3--;
      rdata3 = (cd3 == 0) ? (32'hCAFE_0000 | raddr3) : (32'h0BAD_0000 | 32'(cyc));
    end else begin
      rdata3 = 32'h0BAD_0000 | 32'(cyc);
    end
  end

  // Bus pulse monitor against the expected command order.
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (wen || ren) begin
      check("en_exclusive", 64'(wen && ren), 64'(0));
      check("en_single_cycle", 64'(prev_en), 64'(0));
      pulse_cyc.push_back(cyc);
      if (bus_q.size() == 0) begin
        check("bus_expected_pending", 64'(bus_q.size()), 64'(1));
      end else begin
        bus_t e;
        e = bus_q.pop_front();
        check("bus_write", 64'(wen), 64'(e.write));
        check("bus_addr", 64'(wen ? waddr : raddr), 64'(e.addr));
        if (e.write) check("bus_wdata", 64'(wdata), 64'(e.data));
      end
    end
    prev_en = wen || ren;
  end

  // Response monitor: ordering, content and stability while stalled.
  logic        hold_v = 1'b0, hold_w = 1'b0, hold_e = 1'b0;
  logic [31:0] hold_d = '0;
  always @(negedge clk) begin
    if (hold_v) begin
      check("rsp_hold_valid", 64'(rsp_valid), 64'(1));
      check("rsp_hold_data", 64'(rsp_data), 64'(hold_d));
      check("rsp_hold_flags", 64'({rsp_write, rsp_err}), 64'({hold_w, hold_e}));
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      if (rsp_q.size() == 0) begin
        check("rsp_expected_pending", 64'(rsp_q.size()), 64'(1));
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_write", 64'(rsp_write), 64'(e.write));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
    hold_v = rsp_valid && !rsp_ready;
    hold_d = rsp_data;
    hold_w = rsp_write;
    hold_e = rsp_err;
  end

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic exp_rsp);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && g < 200) begin
      tick();
      g++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    bus_q.push_back('{write: w, addr: a, data: d});
    if (exp_rsp) rsp_q.push_back('{write: w, data: (w ? 32'h0 : exp_rdata), err: exp_err});
    tick();
    n_acc++;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0) && g < 500) begin
      tick();
      g++;
    end
    check("drain_bus_q", 64'(bus_q.size()), 64'(0));
    check("drain_rsp_q", 64'(rsp_q.size()), 64'(0));
    repeat (2) tick();
  endtask

  initial begin
    int g;
    int base;
    int acc_base;
    int p;
    for (int i = 0; i < 16; i++) smem[i] = '0;
    #1;
    check("rst_flags", 64'({wen, ren, rsp_valid, rsp_write, rsp_err, cmd_ready}), 64'(0));
    check("rst_wbus", {waddr, wdata}, 64'(0));
    check("rst_rbus", {raddr, rsp_data}, 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("ready_after_rst", 64'(cmd_ready), 64'(1));

    // Back-to-back writes with the response side always ready.
    rsp_ready = 1'b1;
    pulse_cyc.delete();
    base = n_rsp;
    push_cmd(1'b1, 32'd1, 32'd13021, 32'd0, 1'b0, 1'b1);
    push_cmd(1'b1, 32'd2, 32'h55,    32'd0, 1'b0, 1'b1);
    push_cmd(1'b1, 32'd0, 32'h05,    32'd0, 1'b0, 1'b1);
    drain();
    check("wr_pulse_count", 64'(pulse_cyc.size()), 64'(3));
    check("wr_spacing_01", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'(LAT + 3));
    check("wr_spacing_12", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'(LAT + 3));
    check("wr_rsp_count", 64'(n_rsp - base), 64'(3));

    // Read back, then an erroring write followed by a clean one.
    push_cmd(1'b0, 32'd1, 32'd0, 32'd13021, 1'b0, 1'b1);
    drain();
    push_cmd(1'b1, 32'd7, 32'h77, 32'd0, 1'b1, 1'b1);
    push_cmd(1'b1, 32'd3, 32'h33, 32'd0, 1'b0, 1'b1);
    drain();

    // Stall responses and overfill the command FIFO.
    rsp_ready = 1'b0;
    pulse_cyc.delete();
    base     = n_rsp;
    acc_base = n_acc;
    fork
      begin
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
          if (i % 2 == 0) push_cmd(1'b1, 32'(8 + i), 32'(32'h100 + i), 32'd0, 1'b0, 1'b1);
          else            push_cmd(1'b0, 32'd1, 32'd0, 32'd13021, 1'b0, 1'b1);
        end
      end
      begin
        repeat (20) tick();
        check("stall_cmd_ready", 64'(cmd_ready), 64'(0));
        check("stall_accepted", 64'(n_acc - acc_base), 64'(DEPTH + 1));
        check("stall_pulses", 64'(pulse_cyc.size()), 64'(1));
        check("stall_rsp_valid", 64'(rsp_valid), 64'(1));
        rsp_ready = 1'b1;
      end
    join
    drain();
    check("stall_rsp_count", 64'(n_rsp - base), 64'(DEPTH + 2));

    // Reset in the WAIT state of a read: no response may follow.
    push_cmd(1'b0, 32'd1, 32'd0, 32'd13021, 1'b0, 1'b0);
    g = 0;
    while (!ren && g < 50) begin
      tick();
      g++;
    end
    check("rst_read_pulse", 64'(ren), 64'(1));
    tick();
    rst_n = 1'b0;
    #1;
    check("rstw_flags", 64'({wen, ren, rsp_valid, rsp_write, rsp_err, cmd_ready}), 64'(0));
    check("rstw_wbus", {waddr, wdata}, 64'(0));
    check("rstw_rbus", {raddr, rsp_data}, 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    pulse_cyc.delete();
    base = n_rsp;
    repeat (10) tick();
    check("rstw_no_pulse", 64'(pulse_cyc.size()), 64'(0));
    check("rstw_no_rsp", 64'(n_rsp - base), 64'(0));
    check("rstw_ready", 64'(cmd_ready), 64'(1));
    push_cmd(1'b1, 32'd4, 32'h44, 32'd0, 1'b0, 1'b1);
    drain();
    check("rstw_new_rsp", 64'(n_rsp - base), 64'(1));

    // Latency-3 instance: data must be taken exactly at P+3.
    check("l3_ready", 64'(cmd_ready3), 64'(1));
    cmd_valid3 = 1'b1;
    cmd_addr3  = 32'd2;
    tick();
    cmd_valid3 = 1'b0;
    g = 0;
    while (!ren3 && g < 50) begin
      tick();
      g++;
    end
    check("l3_pulse", 64'(ren3), 64'(1));
    check("l3_raddr", 64'(raddr3), 64'(2));
    p = cyc;
    g = 0;
    while (!rsp_valid3 && g < 50) begin
      tick();
      g++;
    end
    check("l3_rsp_valid", 64'(rsp_valid3), 64'(1));
    check("l3_rsp_delay", 64'(cyc - p), 64'(LAT3 + 1));
    check("l3_rsp_data", 64'(rsp_data3), 64'(32'hCAFE_0002));
    check("l3_rsp_flags", 64'({rsp_write3, rsp_err3, wen3}), 64'(0));
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
